// File: rtl/audio_frame_pkg.sv
// -----------------------------------------------------------------------------
// audio_frame_pkg
// Shared definitions for the audio ping-pong frame controller:
//   - default address/data widths, RAM read latency and return-buffer depth
//   - read-side FSM state encoding
//   - frame_len(): words per half-bank for a given RAM address width
// -----------------------------------------------------------------------------
package audio_frame_pkg;

   localparam int ADDR_WIDTH_DEF = 10;
   localparam int DATA_WIDTH_DEF = 16;
   localparam int RD_LATENCY_DEF = 2;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   // One frame is one half of the RAM: the top address bit selects the bank.
   function automatic int frame_len(input int addr_width);
      return int'(32'd1 << (addr_width - 1));
   endfunction

endpackage

// File: rtl/pp_rd_fifo.sv
// -----------------------------------------------------------------------------
// pp_rd_fifo
// Small synchronous FIFO that buffers words returning from the RAM so the
// frame consumer can stall without losing data in the fixed-latency read pipe.
// Each entry carries {last, data}.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, wdata write one entry (ignored when full; the caller's credit
//               scheme keeps that from happening)
//   pop         remove the head entry (ignored when empty)
//   rdata       head entry, stable until popped
//   count       number of stored entries
//   empty       no entries stored
// -----------------------------------------------------------------------------
module pp_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 17
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             empty_s;
   logic             full_s;
   logic             do_push_s;
   logic             do_pop_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return ptr + PTR_W'(1);
      end
   endfunction

   // Qualify requests against the current fill level.
   always_comb begin
      empty_s   = (count_r == {CNT_W{1'b0}});
      full_s    = (count_r == CNT_W'(DEPTH));
      do_push_s = push & ~full_s;
      do_pop_s  = pop & ~empty_s;
   end

   // Storage array; cleared on reset so the head reads as zero when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (do_pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;
   assign empty = empty_s;

endmodule

// File: rtl/audio_pingpong_frame_ctrl.sv
// -----------------------------------------------------------------------------
// audio_pingpong_frame_ctrl
// Writes an unthrottled sample stream into two half-banks of a simple
// dual-port RAM (ping-pong), and reads each completed half-bank back as one
// frame over a valid/ready interface. The RAM has a fixed read latency with
// no read enable, so returning words land in a small FIFO; issue is gated by
// a credit count so that FIFO can never overflow while the consumer stalls.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_data, s_valid            input samples (no backpressure)
//   overflow                   1-cycle pulse when a sample is dropped
//   ram_wr_data/addr/en        RAM write port (registered)
//   ram_rd_addr, ram_rd_data   RAM read port
//   m_data, m_valid, m_ready   frame output stream
//   m_last                     final word of the frame
// -----------------------------------------------------------------------------
module audio_pingpong_frame_ctrl
   import audio_frame_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int RD_LATENCY = RD_LATENCY_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  overflow,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
);

   localparam int OFS_W = ADDR_WIDTH - 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int INF_W = $clog2(RD_LATENCY + 1);
   localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

   // ---------------------------------------------------------------- write side
   logic [ADDR_WIDTH-1:0] wr_ptr_r;
   logic [1:0]            full_r;
   logic [1:0]            full_nxt_s;
   logic [1:0]            set_mask_s;
   logic [1:0]            clr_mask_s;
   logic                  wr_bank_s;
   logic                  wr_accept_s;
   logic                  wr_drop_s;
   logic                  wr_frame_end_s;
   logic [DATA_WIDTH-1:0] wr_data_r;
   logic [ADDR_WIDTH-1:0] wr_addr_r;
   logic                  wr_en_r;
   logic                  overflow_r;

   // ----------------------------------------------------------------- read side
   rd_state_t             state_r;
   rd_state_t             state_nxt_s;
   logic                  rd_bank_r;
   logic [OFS_W-1:0]      rd_cnt_r;
   logic                  issue_s;
   logic                  issue_last_s;
   logic                  frame_done_s;
   logic [RD_LATENCY-1:0] vld_pipe_r;
   logic [RD_LATENCY-1:0] last_pipe_r;
   logic [INF_W-1:0]      inflight_s;
   logic [OCC_W-1:0]      occupancy_s;
   logic                  credit_ok_s;
   logic [CNT_W-1:0]      fifo_count_s;
   logic                  fifo_empty_s;
   logic [DATA_WIDTH:0]   fifo_head_s;
   logic                  out_valid_s;
   logic                  pop_s;

   // Accept or drop the incoming sample based on its target bank's full flag.
   always_comb begin
      wr_bank_s      = wr_ptr_r[ADDR_WIDTH-1];
      wr_accept_s    = 1'b0;
      wr_drop_s      = 1'b0;
      wr_frame_end_s = 1'b0;
      if (s_valid) begin
         if (full_r[wr_bank_s]) begin
            wr_drop_s = 1'b1;
         end else begin
            wr_accept_s    = 1'b1;
            wr_frame_end_s = (wr_ptr_r[OFS_W-1:0] == {OFS_W{1'b1}});
         end
      end else begin
         wr_accept_s = 1'b0;
      end
   end

   // Registered RAM write port, write pointer and overflow pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
         wr_en_r    <= 1'b0;
         wr_addr_r  <= {ADDR_WIDTH{1'b0}};
         wr_data_r  <= {DATA_WIDTH{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         wr_en_r    <= wr_accept_s;
         overflow_r <= wr_drop_s;
         if (wr_accept_s) begin
            wr_addr_r <= wr_ptr_r;
            wr_data_r <= s_data;
            wr_ptr_r  <= wr_ptr_r + ADDR_WIDTH'(1);
         end
      end
   end

   // Bank full flags: the writer sets on its last word, the reader clears
   // after the consumer takes m_last. They never target the same bank at once.
   always_comb begin
      set_mask_s = 2'b00;
      clr_mask_s = 2'b00;
      if (wr_accept_s && wr_frame_end_s) begin
         set_mask_s[wr_bank_s] = 1'b1;
      end else begin
         set_mask_s = 2'b00;
      end
      if (frame_done_s) begin
         clr_mask_s[rd_bank_r] = 1'b1;
      end else begin
         clr_mask_s = 2'b00;
      end
      full_nxt_s = (full_r | set_mask_s) & ~clr_mask_s;
   end

   // Full flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_r <= 2'b00;
      end else begin
         full_r <= full_nxt_s;
      end
   end

   // Words already committed to the FIFO: in the read pipe plus stored.
   always_comb begin
      inflight_s = {INF_W{1'b0}};
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight_s = inflight_s + INF_W'(vld_pipe_r[i]);
      end
      occupancy_s = OCC_W'(fifo_count_s) + OCC_W'(inflight_s);
      credit_ok_s = (occupancy_s < OCC_W'(FIFO_DEPTH));
   end

   // Read FSM next state, issue strobe and end-of-frame handover.
   always_comb begin
      state_nxt_s  = state_r;
      issue_s      = 1'b0;
      issue_last_s = 1'b0;
      frame_done_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (full_r[rd_bank_r]) begin
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (credit_ok_s) begin
               issue_s      = 1'b1;
               issue_last_s = (rd_cnt_r == {OFS_W{1'b1}});
               if (issue_last_s) begin
                  state_nxt_s = DRAIN;
               end else begin
                  state_nxt_s = ISSUE;
               end
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         DRAIN: begin
            if ((inflight_s == {INF_W{1'b0}}) && pop_s && fifo_head_s[DATA_WIDTH]) begin
               frame_done_s = 1'b1;
               state_nxt_s  = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Read FSM state, frame word counter and current read bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         rd_cnt_r  <= {OFS_W{1'b0}};
         rd_bank_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (state_r == IDLE) begin
            rd_cnt_r <= {OFS_W{1'b0}};
         end else if (issue_s) begin
            rd_cnt_r <= rd_cnt_r + OFS_W'(1);
         end
         if (frame_done_s) begin
            rd_bank_r <= ~rd_bank_r;
         end
      end
   end

   // The read address is presented in the same cycle as the credit decision,
   // so the address cycle is the issue cycle and the pipe below starts there.
   always_comb begin
      if (issue_s) begin
         ram_rd_addr = {rd_bank_r, rd_cnt_r};
      end else begin
         ram_rd_addr = {ADDR_WIDTH{1'b0}};
      end
   end

   // Valid/last shift registers mirroring the RAM's fixed read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_r  <= {RD_LATENCY{1'b0}};
         last_pipe_r <= {RD_LATENCY{1'b0}};
      end else begin
         vld_pipe_r[0]  <= issue_s;
         last_pipe_r[0] <= issue_last_s;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_r[i]  <= vld_pipe_r[i-1];
            last_pipe_r[i] <= last_pipe_r[i-1];
         end
      end
   end

   assign out_valid_s = ~fifo_empty_s;
   assign pop_s       = out_valid_s & m_ready;

   pp_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH + 1)
   ) u_rd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (vld_pipe_r[RD_LATENCY-1]),
      .wdata ({last_pipe_r[RD_LATENCY-1], ram_rd_data}),
      .pop   (pop_s),
      .rdata (fifo_head_s),
      .count (fifo_count_s),
      .empty (fifo_empty_s)
   );

   assign ram_wr_en   = wr_en_r;
   assign ram_wr_addr = wr_addr_r;
   assign ram_wr_data = wr_data_r;
   assign overflow    = overflow_r;
   assign m_valid     = out_valid_s;
   assign m_data      = fifo_head_s[DATA_WIDTH-1:0];
   assign m_last      = fifo_head_s[DATA_WIDTH];

endmodule

// File: tb/tb_audio_pingpong_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for audio_pingpong_frame_ctrl. A driver issues samples and consumer
// ready; a frame-level model predicts the accepted sample stream, RAM writes
// and dropped samples into queues; a monitor on the falling edge pops and
// compares whenever the DUT presents a write, an overflow or an accepted word.
// -----------------------------------------------------------------------------
module tb_audio_pingpong_frame_ctrl;

   localparam int AW = 10;
   localparam int DW = 16;
   localparam int FL = 512;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          overflow;
   logic [DW-1:0] ram_wr_data;
   logic [AW-1:0] ram_wr_addr;
   logic          ram_wr_en;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic          m_last;

   always #5 clk = ~clk;

   audio_pingpong_frame_ctrl dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
      .overflow(overflow), .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr),
      .ram_wr_en(ram_wr_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
   );

   // SDP RAM: registered read plus output register = 2-cycle latency.
   logic [DW-1:0] ram_mem [0:(1<<AW)-1];
   logic [DW-1:0] rd_s1;
   always @(posedge clk) begin
      if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
      rd_s1       <= ram_mem[ram_rd_addr];
      ram_rd_data <= rd_s1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Frame-level reference model and scoreboard queues.
   int             n_checks = 0;
   int             n_fail = 0;
   int             mdl_wr_ptr = 0;
   bit             mdl_full [2];
   int             mdl_rd_bank = 0;
   logic [DW:0]    exp_q [$];     // {last, data} in output order
   logic [AW+DW-1:0] wr_q [$];    // {addr, data} of RAM writes
   int             ovf_q [$];     // cycles in which overflow must be seen
   int             mode = 0;      // 0 ready=1, 1 toggle, 2 ready=0, 3 random
   int             pops = 0;
   bit             chk_run = 1'b0;
   int             run = 0;
   bit             stalled = 1'b0;
   logic [DW-1:0]  held_d;
   logic           held_l;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      wr_q.delete();
      ovf_q.delete();
      mdl_wr_ptr  = 0;
      mdl_full[0] = 1'b0;
      mdl_full[1] = 1'b0;
      mdl_rd_bank = 0;
   endtask

   // Sample goes to bank = top address bit; dropped if that bank holds an unread frame.
   task automatic model_sample(input logic [DW-1:0] d);
      int  bank;
      bit  last;
      logic [AW-1:0] a;
      bank = (mdl_wr_ptr / FL) % 2;
      if (mdl_full[bank]) begin
         ovf_q.push_back(cyc + 1);
      end else begin
         a    = AW'(mdl_wr_ptr);
         last = ((mdl_wr_ptr % FL) == FL - 1);
         wr_q.push_back({a, d});
         exp_q.push_back({last, d});
         if (last) mdl_full[bank] = 1'b1;
         mdl_wr_ptr = (mdl_wr_ptr + 1) % (2 * FL);
      end
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      s_valid = v;
      s_data  = d;
      case (mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ((cyc % 2) == 0);
         2:       m_ready = 1'b0;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (v) model_sample(d);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || wr_q.size() != 0 || ovf_q.size() != 0) && n < 4000) begin
         drive(1'b0, '0);
         n++;
      end
      if (n >= 4000) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      end
   endtask

   // Called between clock edges: async reset must zero every output at once.
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
      chk("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
      chk("rst_wr_data", 32'(ram_wr_data), 32'd0);
      chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
      model_clear();
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: compare whatever the DUT presents this cycle.
   always @(negedge clk) begin
      logic [AW+DW-1:0] we;
      logic [DW:0]      oe;
      bit               exp_ovf;
      if (!rst_n) begin
         stalled = 1'b0;
         run     = 0;
      end else begin
         if (ram_wr_en) begin
            chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
               we = wr_q.pop_front();
               chk("wr_addr", 32'(ram_wr_addr), 32'(we[AW+DW-1:DW]));
               chk("wr_data", 32'(ram_wr_data), 32'(we[DW-1:0]));
            end
         end
         exp_ovf = (ovf_q.size() != 0) && (ovf_q[0] == cyc);
         chk("overflow", 32'(overflow), 32'(exp_ovf));
         if (exp_ovf) void'(ovf_q.pop_front());
         if (stalled) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(held_d));
            chk("stall_last", 32'(m_last), 32'(held_l));
         end
         run = m_valid ? run + 1 : 0;
         if (m_valid && m_ready) begin
            chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               oe = exp_q.pop_front();
               chk("m_data", 32'(m_data), 32'(oe[DW-1:0]));
               chk("m_last", 32'(m_last), 32'(oe[DW]));
               pops++;
               if (oe[DW]) begin
                  if (chk_run) chk("valid_run", 32'(run), 32'(FL));
                  mdl_full[mdl_rd_bank] = 1'b0;
                  mdl_rd_bank = 1 - mdl_rd_bank;
               end
            end
         end
         stalled = m_valid && !m_ready;
         held_d  = m_data;
         held_l  = m_last;
      end
   end

   initial begin
      int base;
      int n;
      #2;
      apply_reset();

      // 1: one ramp frame, consumer always ready, frame is one unbroken burst.
      mode = 0;
      chk_run = 1'b1;
      for (int i = 0; i < FL; i++) drive(1'b1, DW'(i));
      wait_drain();
      chk_run = 1'b0;

      // 2: two frames with ready toggling 1010.
      mode = 1;
      for (int i = 0; i < 2 * FL; i++) drive(1'b1, DW'(i));
      wait_drain();

      // 3: consumer stalled: both banks fill, one more sample is dropped.
      @(posedge clk);
      #3;
      apply_reset();
      mode = 2;
      for (int i = 0; i <= 2 * FL; i++) drive(1'b1, DW'(16'h4000 + i));
      repeat (20) drive(1'b0, '0);
      mode = 0;
      wait_drain();

      // 4: random samples and random ready, then complete the partial frame.
      mode = 3;
      for (int i = 0; i < 3000; i++) drive(($urandom_range(0, 3) != 0), DW'($urandom));
      mode = 0;
      n = 0;
      while ((mdl_wr_ptr % FL) != 0 && n < 3000) begin
         drive(1'b1, DW'($urandom));
         n++;
      end
      wait_drain();

      // 5: reset in the middle of a frame read, then a clean ramp.
      mode = 0;
      for (int i = 0; i < FL; i++) drive(1'b1, DW'(16'h2000 + i));
      base = pops;
      n = 0;
      while (pops < base + 200 && n < 2000) begin
         drive(1'b0, '0);
         n++;
      end
      if (n >= 2000) begin
         n_checks++;
         n_fail++;
         $display("FAIL reset_point_timeout: %0d words read, required 200", pops - base);
      end
      #2;
      apply_reset();
      chk_run = 1'b1;
      for (int i = 0; i < FL; i++) drive(1'b1, DW'(i));
      wait_drain();
      chk_run = 1'b0;

      repeat (5) drive(1'b0, '0);
      chk("left_words", 32'(exp_q.size()), 32'd0);
      chk("left_writes", 32'(wr_q.size()), 32'd0);
      chk("idle_valid", 32'(m_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
